// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: states, opcodes,
// ALU operation classes and the packed control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Control-word decode: maps current state and mem_ready to datapath controls.
// Latency: combinational, zero cycles.
// Backpressure: mem_ready only gates IR/PC load in FETCH and done in MEM_WRITE.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/mem/wb.
// Latency: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles with memory ready.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold while mem_ready is low.
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [ST_W-1:0]  state
);

    state_t state_q;
    ctrl_t  ctrl;

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_q <= S_FETCH;
                S_FETCH:  state_q <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_J:         state_q <= S_JUMP;
                        OP_ADDI:      state_q <= S_ADDI_EXEC;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                // IR holds the opcode here, so only lw/sw can reach this state.
                S_MEM_ADDR:  state_q <= (opcode == OP_LW) ? S_MEM_READ :
                                        (opcode == OP_SW) ? S_MEM_WRITE : S_FETCH;
                S_MEM_READ:  state_q <= mem_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WRITE: state_q <= mem_ready ? S_FETCH : S_MEM_WRITE;
                S_EXECUTE:   state_q <= S_R_WB;
                S_ADDI_EXEC: state_q <= S_ADDI_WB;
                default:     state_q <= S_FETCH;
            endcase
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = (state_q == S_DECODE) && !op_legal(6'(opcode));
    assign state         = ST_W'(state_q);

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sits directly upstream of alu_control: produces the 2-bit alu_op it consumes, plus every datapath mux, register-file, memory and PC enable.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Stalls on a memory-ready handshake and flags illegal opcodes.

Parameters:
- OPC_W, 6, opcode field width.
- ST_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_to_reg  output  1  write-back data: 0=ALUOut, 1=MDR
- ir_write  output  1  IR load
- pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
- alu_op  output  2  to alu_control: 00=add, 01=sub, 10=funct
- alu_src_a  output  1  0=PC, 1=rs reg A
- alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- reg_write  output  1  register-file write enable
- reg_dst  output  1  0=rt, 1=rd
- instr_done  output  1  one-cycle pulse on the final cycle of an instruction
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode
- state  output  4  current state, for debug

Behaviour:
- Reset: in any cycle where rst=1, state <= IDLE on the next edge. In IDLE every output is 0, with state=0. IDLE -> FETCH unconditionally on the next cycle.
- Outputs are decoded combinationally from state. Only pc_write, ir_write and instr_done are also qualified by mem_ready, as noted below. Outputs not listed for a state are 0.
- States and encodings:
  - IDLE=0.
  - FETCH=1: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
  - DECODE=2: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - 100011 lw, 101011 sw -> MEM_ADDR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 000010 j -> JUMP
    - 001000 addi -> ADDI_EXEC
    - any other opcode: illegal_op=1 -> FETCH
  - MEM_ADDR=3: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ, sw -> MEM_WRITE. Opcode is held stable by the IR.
  - MEM_READ=4: mem_read=1, i_or_d=1. Hold until mem_ready=1, then -> MEM_WB.
  - MEM_WB=5: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
  - MEM_WRITE=6: mem_write=1, i_or_d=1, held across the stall; instr_done=mem_ready. Leave for FETCH when mem_ready=1.
  - EXECUTE=7: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
  - R_WB=8: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
  - BRANCH=9: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
  - JUMP=10: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
  - ADDI_EXEC=11: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
  - ADDI_WB=12: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
- Unused encodings 13-15: all outputs 0, next state FETCH.
- Latency with mem_ready tied 1, in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready is ignored outside those three states.
- rst asserted mid-instruction aborts it: the next state is IDLE regardless of current state or mem_ready. No write strobe is asserted in IDLE.
- reg_write and mem_write are never both 1. pc_write and pc_write_cond are never both 1.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encoding constants S_IDLE..S_ADDI_WB
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - alu_op constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
- One combinational sub-module, mc_ctrl_decode: maps state and mem_ready to the output vector. The parent keeps the state register and next-state logic.

Test Plan:
- rst=1 for 2 cycles, then 0 -> state=0 with all outputs 0 during reset; state=1 and mem_read=1 one cycle after release.
- lw (opcode 100011), mem_ready=1 -> states 1,2,3,4,5; reg_write=1 with mem_to_reg=1 in state 5; instr_done pulses once; back in FETCH on cycle 6.
- R-type (000000) -> alu_op=10 in EXECUTE; R_WB has reg_dst=1, reg_write=1. beq (000100) -> alu_op=01 and pc_write_cond=1 in BRANCH.
- sw with mem_ready=0 for 3 cycles in MEM_WRITE -> mem_write stays 1 for 4 cycles; instr_done only in the last; sw total 7 cycles.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=pc_write=0 while stalled; both 1 only in the ready cycle.
- Opcode 111111 -> illegal_op=1 in DECODE, return to FETCH, no reg_write or mem_write. rst=1 during MEM_READ -> IDLE next cycle, all outputs 0.
